// File: rtl/smpte_line_crc_insert.sv
// HD-SDI line CRC generator/inserter: follows the TRS/line structure of a 20-bit Y/C stream, accumulates
// one 18-bit CRC per channel and writes it into the CR0/CR1 words that follow EAV+LN0+LN1.
module smpte_line_crc_insert #(
   parameter logic INSERT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din_valid,
   input  logic [9:0]  din_y,
   input  logic [9:0]  din_c,
   output logic        dout_valid,
   output logic [9:0]  dout_y,
   output logic [9:0]  dout_c,
   output logic [17:0] crc_y,
   output logic [17:0] crc_c,
   output logic        crc_stb,
   output logic        sync_err
);

   // Reflected form of x^18+x^5+x^4+1 for a right-shifting, LSB-first register.
   localparam logic [17:0] CRC_POLY = 18'h23000;

   typedef enum logic [2:0] {
      BLANK,
      ACTIVE,
      LN0,
      LN1,
      CR0,
      CR1
   } state_t;

   state_t      state_q;
   logic [17:0] accY_q;
   logic [17:0] accC_q;
   logic        lineOk_q;
   logic [9:0]  hist0_q;
   logic [9:0]  hist1_q;
   logic [9:0]  hist2_q;
   logic        doutValid_q;
   logic [9:0]  doutY_q;
   logic [9:0]  doutC_q;
   logic [17:0] crcY_q;
   logic [17:0] crcC_q;
   logic        crcStb_q;
   logic        syncErr_q;

   logic [17:0] accY_d;
   logic [17:0] accC_d;
   logic        trsDet;
   logic        isEav;
   logic        isSav;
   logic [9:0]  cr0Y;
   logic [9:0]  cr0C;
   logic [9:0]  cr1Y;
   logic [9:0]  cr1C;

   function automatic logic [17:0] crcStep(input logic [17:0] crc, input logic [9:0] d);
      logic [17:0] r;
      r = crc;
      for (int i = 0; i < 10; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
         else             r = r >> 1;
      end
      return r;
   endfunction

   always_comb begin
      accY_d = crcStep(accY_q, din_y);
      accC_d = crcStep(accC_q, din_c);
      trsDet = (hist2_q == 10'h3FF) && (hist1_q == 10'h000) && (hist0_q == 10'h000) && din_y[9];
      isEav  = trsDet && din_y[6];
      isSav  = trsDet && !din_y[6];
      // Bit 9 of each CR word is the inverse of bit 8 so the word can never alias a TRS code.
      cr0Y   = {~accY_q[8],  accY_q[8:0]};
      cr0C   = {~accC_q[8],  accC_q[8:0]};
      cr1Y   = {~accY_q[17], accY_q[17:9]};
      cr1C   = {~accC_q[17], accC_q[17:9]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BLANK;
         accY_q      <= '0;
         accC_q      <= '0;
         lineOk_q    <= 1'b0;
         hist0_q     <= '0;
         hist1_q     <= '0;
         hist2_q     <= '0;
         doutValid_q <= 1'b0;
         doutY_q     <= '0;
         doutC_q     <= '0;
         crcY_q      <= '0;
         crcC_q      <= '0;
         crcStb_q    <= 1'b0;
         syncErr_q   <= 1'b0;
      end else begin
         doutValid_q <= din_valid;
         crcStb_q    <= 1'b0;
         syncErr_q   <= 1'b0;
         if (din_valid) begin
            hist2_q <= hist1_q;
            hist1_q <= hist0_q;
            hist0_q <= din_y;
            doutY_q <= din_y;
            doutC_q <= din_c;
            case (state_q)
               BLANK: begin
                  if (isSav) begin
                     accY_q   <= '0;
                     accC_q   <= '0;
                     lineOk_q <= 1'b1;
                     state_q  <= ACTIVE;
                  end else if (isEav) begin
                     lineOk_q  <= 1'b0;
                     syncErr_q <= 1'b1;
                     state_q   <= LN0;
                  end
               end
               ACTIVE: begin
                  if (isSav) begin
                     accY_q    <= '0;
                     accC_q    <= '0;
                     syncErr_q <= 1'b1;
                  end else begin
                     accY_q <= accY_d;
                     accC_q <= accC_d;
                     if (isEav) state_q <= LN0;
                  end
               end
               LN0, LN1, CR0, CR1: begin
                  if (trsDet) begin
                     // A TRS inside the LN/CR trailer breaks the line; resync on it.
                     syncErr_q <= 1'b1;
                     accY_q    <= '0;
                     accC_q    <= '0;
                     lineOk_q  <= isSav;
                     state_q   <= isSav ? ACTIVE : LN0;
                  end else begin
                     case (state_q)
                        LN0, LN1: begin
                           if (lineOk_q) begin
                              accY_q <= accY_d;
                              accC_q <= accC_d;
                           end
                           state_q <= (state_q == LN0) ? LN1 : CR0;
                        end
                        CR0: begin
                           if (INSERT_EN && lineOk_q) begin
                              doutY_q <= cr0Y;
                              doutC_q <= cr0C;
                           end
                           state_q <= CR1;
                        end
                        default: begin
                           if (INSERT_EN && lineOk_q) begin
                              doutY_q <= cr1Y;
                              doutC_q <= cr1C;
                           end
                           if (lineOk_q) begin
                              crcY_q   <= accY_q;
                              crcC_q   <= accC_q;
                              crcStb_q <= 1'b1;
                           end
                           accY_q   <= '0;
                           accC_q   <= '0;
                           lineOk_q <= 1'b0;
                           state_q  <= BLANK;
                        end
                     endcase
                  end
               end
               default: state_q <= BLANK;
            endcase
         end
      end
   end

   assign dout_valid = doutValid_q;
   assign dout_y     = doutY_q;
   assign dout_c     = doutC_q;
   assign crc_y      = crcY_q;
   assign crc_c      = crcC_q;
   assign crc_stb    = crcStb_q;
   assign sync_err   = syncErr_q;

endmodule

// File: tb/tb_smpte_line_crc_insert.sv
// Scoreboard bench for smpte_line_crc_insert: one inserting instance and one pass-through instance
// share the same stimulus; expected words are queued at issue and popped by a monitor on dout_valid.
module tb_smpte_line_crc_insert;

   typedef struct packed {
      logic [9:0]  y;
      logic [9:0]  c;
      logic        syncErr;
      logic        crcStb;
      logic [17:0] crcY;
      logic [17:0] crcC;
   } exp_t;

   localparam logic [9:0] XYZ_SAV = 10'h200;
   localparam logic [9:0] XYZ_EAV = 10'h274;

   logic        clk = 1'b0;
   logic        rst;
   logic        din_valid;
   logic [9:0]  din_y;
   logic [9:0]  din_c;

   logic        aDoutValid, pDoutValid;
   logic [9:0]  aDoutY, aDoutC, pDoutY, pDoutC;
   logic [17:0] aCrcY, aCrcC, pCrcY, pCrcC;
   logic        aCrcStb, aSyncErr, pCrcStb, pSyncErr;

   exp_t        expQ[$];
   exp_t        expQ0[$];
   int          checks = 0;
   int          errors = 0;
   logic [17:0] mAccY;
   logic [17:0] mAccC;
   bit          toggleMode;
   logic        expDv = 1'b0;

   always #5 clk = ~clk;

   smpte_line_crc_insert #(.INSERT_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din_y(din_y), .din_c(din_c),
      .dout_valid(aDoutValid), .dout_y(aDoutY), .dout_c(aDoutC),
      .crc_y(aCrcY), .crc_c(aCrcC), .crc_stb(aCrcStb), .sync_err(aSyncErr)
   );

   smpte_line_crc_insert #(.INSERT_EN(1'b0)) dutPass (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din_y(din_y), .din_c(din_c),
      .dout_valid(pDoutValid), .dout_y(pDoutY), .dout_c(pDoutC),
      .crc_y(pCrcY), .crc_c(pCrcC), .crc_stb(pCrcStb), .sync_err(pSyncErr)
   );

   // Bit-serial CRC: each input bit enters LSB-first; feedback lands on the x^0, x^4 and x^5 taps.
   function automatic logic [17:0] crcModel(input logic [17:0] c, input logic [9:0] d);
      logic [17:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 10; i++) begin
         fb    = r[0] ^ d[i];
         r     = {fb, r[17:1]};
         r[13] = r[13] ^ fb;
         r[12] = r[12] ^ fb;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkPort(input string tag, input bit isPass, input logic dv,
                            input logic [9:0] y, input logic [9:0] c, input logic se, input logic stb,
                            input logic [17:0] cy, input logic [17:0] cc);
      exp_t e;
      bit   empty;
      if (dv === 1'b1) begin
         empty = isPass ? (expQ0.size() == 0) : (expQ.size() == 0);
         if (empty) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.unexpectedOutput: got dout_valid=1 required empty scoreboard", tag);
         end else begin
            if (isPass) e = expQ0.pop_front();
            else        e = expQ.pop_front();
            checkOutput({tag, ".doutY"}, {22'd0, y}, {22'd0, e.y});
            checkOutput({tag, ".doutC"}, {22'd0, c}, {22'd0, e.c});
            checkOutput({tag, ".syncErr"}, {31'd0, se}, {31'd0, e.syncErr});
            checkOutput({tag, ".crcStb"}, {31'd0, stb}, {31'd0, e.crcStb});
            if (e.crcStb) begin
               checkOutput({tag, ".crcY"}, {14'd0, cy}, {14'd0, e.crcY});
               checkOutput({tag, ".crcC"}, {14'd0, cc}, {14'd0, e.crcC});
            end
         end
      end else begin
         checkOutput({tag, ".syncErrIdle"}, {31'd0, se}, 32'd0);
         checkOutput({tag, ".crcStbIdle"}, {31'd0, stb}, 32'd0);
      end
   endtask

   // Expected dout_valid is the driven din_valid one clock later, forced low by reset.
   always @(posedge clk) expDv <= rst ? 1'b0 : din_valid;

   always @(negedge clk) begin
      checkOutput("ins.doutValid", {31'd0, aDoutValid}, {31'd0, expDv});
      checkOutput("pass.doutValid", {31'd0, pDoutValid}, {31'd0, expDv});
      checkPort("ins", 1'b0, aDoutValid, aDoutY, aDoutC, aSyncErr, aCrcStb, aCrcY, aCrcC);
      checkPort("pass", 1'b1, pDoutValid, pDoutY, pDoutC, pSyncErr, pCrcStb, pCrcY, pCrcC);
   end

   // Drives one valid word; ey/ec are what the inserting instance must emit, the pass-through instance echoes y/c.
   task automatic applyStimulus(input logic [9:0] y, input logic [9:0] c, input logic [9:0] ey,
                                input logic [9:0] ec, input logic se, input logic stb);
      exp_t e;
      exp_t e0;
      din_valid = 1'b1;
      din_y     = y;
      din_c     = c;
      e  = '{y: ey, c: ec, syncErr: se, crcStb: stb, crcY: mAccY, crcC: mAccC};
      e0 = '{y: y,  c: c,  syncErr: se, crcStb: stb, crcY: mAccY, crcC: mAccC};
      expQ.push_back(e);
      expQ0.push_back(e0);
      @(posedge clk);
      #1;
      if (toggleMode) begin
         din_valid = 1'b0;
         din_y     = 10'h3FF;
         din_c     = 10'h3FF;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendIdle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(10'h040, 10'h200, 10'h040, 10'h200, 1'b0, 1'b0);
   endtask

   task automatic sendData(input int n, input logic [9:0] y, input logic [9:0] c);
      for (int i = 0; i < n; i++) begin
         applyStimulus(y, c, y, c, 1'b0, 1'b0);
         mAccY = crcModel(mAccY, y);
         mAccC = crcModel(mAccC, c);
      end
   endtask

   task automatic sendTrs(input logic [9:0] xyz, input bit accumulate, input logic se);
      logic [9:0] w;
      for (int i = 0; i < 4; i++) begin
         w = (i == 0) ? 10'h3FF : ((i == 3) ? xyz : 10'h000);
         applyStimulus(w, w, w, w, (i == 3) ? se : 1'b0, 1'b0);
         if (accumulate) begin
            mAccY = crcModel(mAccY, w);
            mAccC = crcModel(mAccC, w);
         end
      end
   endtask

   task automatic startLine(input logic se);
      sendTrs(XYZ_SAV, 1'b0, se);
      mAccY = '0;
      mAccC = '0;
   endtask

   task automatic sendTail(input bit lineOk, input logic [9:0] crIn);
      logic [9:0] ln;
      logic [9:0] y0, c0, y1, c1;
      for (int i = 0; i < 2; i++) begin
         ln = (i == 0) ? 10'h204 : 10'h200;
         applyStimulus(ln, ln, ln, ln, 1'b0, 1'b0);
         if (lineOk) begin
            mAccY = crcModel(mAccY, ln);
            mAccC = crcModel(mAccC, ln);
         end
      end
      y0 = lineOk ? {~mAccY[8],  mAccY[8:0]}  : crIn;
      c0 = lineOk ? {~mAccC[8],  mAccC[8:0]}  : crIn;
      y1 = lineOk ? {~mAccY[17], mAccY[17:9]} : crIn;
      c1 = lineOk ? {~mAccC[17], mAccC[17:9]} : crIn;
      applyStimulus(crIn, crIn, y0, c0, 1'b0, 1'b0);
      applyStimulus(crIn, crIn, y1, c1, 1'b0, lineOk);
   endtask

   initial begin
      #1000000;
      checks++;
      errors++;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      rst        = 1'b1;
      din_valid  = 1'b1;
      din_y      = 10'h3FF;
      din_c      = 10'h155;
      toggleMode = 1'b0;
      mAccY      = '0;
      mAccC      = '0;

      $display("[TB] reset held with din_valid high");
      repeat (3) begin
         @(negedge clk);
         checkOutput("rst.doutY", {22'd0, aDoutY}, 32'd0);
         checkOutput("rst.doutC", {22'd0, aDoutC}, 32'd0);
         checkOutput("rst.crcY", {14'd0, aCrcY}, 32'd0);
         checkOutput("rst.crcC", {14'd0, aCrcC}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst       = 1'b0;
      din_valid = 1'b0;
      sendIdle(4);

      $display("[TB] nominal 1920-word line");
      startLine(1'b0);
      sendData(1920, 10'h040, 10'h200);
      sendTrs(XYZ_EAV, 1'b1, 1'b0);
      sendTail(1'b1, 10'h000);
      sendIdle(6);

      $display("[TB] EAV without preceding SAV");
      sendTrs(XYZ_EAV, 1'b0, 1'b1);
      sendTail(1'b0, 10'h155);
      sendIdle(6);

      $display("[TB] nominal line with din_valid toggling");
      toggleMode = 1'b1;
      startLine(1'b0);
      sendData(1920, 10'h040, 10'h200);
      sendTrs(XYZ_EAV, 1'b1, 1'b0);
      sendTail(1'b1, 10'h000);
      toggleMode = 1'b0;
      sendIdle(6);

      $display("[TB] repeated SAV inside a line");
      startLine(1'b0);
      sendData(100, 10'h3F0, 10'h123);
      startLine(1'b1);
      sendData(200, 10'h0A5, 10'h15A);
      sendTrs(XYZ_EAV, 1'b1, 1'b0);
      sendTail(1'b1, 10'h000);
      sendIdle(6);

      $display("[TB] reset in mid-line, then EAV without SAV");
      startLine(1'b0);
      sendData(50, 10'h040, 10'h200);
      rst       = 1'b1;
      din_valid = 1'b1;
      din_y     = 10'h040;
      din_c     = 10'h200;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst       = 1'b0;
      din_valid = 1'b0;
      @(posedge clk);
      #1;
      sendTrs(XYZ_EAV, 1'b0, 1'b1);
      sendTail(1'b0, 10'h155);
      sendIdle(3);
      din_valid = 1'b0;

      for (int i = 0; i < 50 && (expQ.size() != 0 || expQ0.size() != 0); i++) @(negedge clk);
      @(negedge clk);
      checkOutput("drain.ins", expQ.size(), 32'd0);
      checkOutput("drain.pass", expQ0.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
